// File: rtl/m_credit_ctr_pkg.sv
// Shared defaults and update classification for the per-VC credit tracker.
// Used by m_credit_ctr and m_credit_ctr_vc.
package m_credit_ctr_pkg;

    localparam int VC_NUM_DEF     = 2;
    localparam int CREDIT_MAX_DEF = 4;
    localparam int CREDIT_W_DEF   = 3;

    typedef enum logic [2:0] {
        UPD_HOLD,
        UPD_NET0,
        UPD_INC,
        UPD_DEC,
        UPD_OVF,
        UPD_UDF
    } upd_e;

    // A simultaneous return and departure cancel out and can never raise an error.
    function automatic upd_e classify_update(
        input logic inc,
        input logic dec,
        input logic full,
        input logic empty
    );
        upd_e r;
        r = UPD_HOLD;
        if (inc && dec) begin
            r = UPD_NET0;
        end else if (inc) begin
            r = full ? UPD_OVF : UPD_INC;
        end else if (dec) begin
            r = empty ? UPD_UDF : UPD_DEC;
        end
        return r;
    endfunction

endpackage

// File: rtl/m_credit_ctr_vc.sv
// Single-VC credit counter with saturation, error strobes and registered edge pulses.
// CREDIT_LOOKAHEAD_EN adds a combinational credit-return bypass to avail.
module m_credit_ctr_vc
    import m_credit_ctr_pkg::*;
#(
    parameter int MAX_CREDIT = CREDIT_MAX_DEF,
    parameter int CREDIT_W   = CREDIT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                dec,
    output logic [CREDIT_W-1:0] cnt,
    output logic                avail,
    output logic                set_pulse,
    output logic                clr_pulse,
    output logic                ovf,
    output logic                udf
);

    localparam logic [CREDIT_W-1:0] FULL_CNT = CREDIT_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] ONE_CNT  = CREDIT_W'(1);

    upd_e                upd;
    logic [CREDIT_W-1:0] cnt_next;
    logic                empty;
    logic                full;

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);

    always_comb begin
        upd      = classify_update(inc, dec, full, empty);
        cnt_next = cnt;
        ovf      = 1'b0;
        udf      = 1'b0;
        case (upd)
            UPD_INC: cnt_next = cnt + ONE_CNT;
            UPD_DEC: cnt_next = cnt - ONE_CNT;
            UPD_OVF: ovf      = 1'b1;
            UPD_UDF: udf      = 1'b1;
            default: cnt_next = cnt;
        endcase
    end

    // Pulses are registered alongside the count so they line up with the count transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= FULL_CNT;
            set_pulse <= 1'b0;
            clr_pulse <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            set_pulse <= empty && (cnt_next != '0);
            clr_pulse <= !empty && (cnt_next == '0);
        end
    end

`ifdef CREDIT_LOOKAHEAD_EN
    assign avail = !empty || (inc && !dec);
`else
    assign avail = !empty;
`endif

endmodule

// File: rtl/m_credit_ctr.sv
// Per-VC credit tracker for a router output port: counters, VC-free flag pulses, sticky errors.
// Optional macro CREDIT_LOOKAHEAD_EN enables the same-cycle credit-return bypass on CREDIT_AVAIL.
module m_credit_ctr
    import m_credit_ctr_pkg::*;
#(
    parameter int VC_NUM     = VC_NUM_DEF,
    parameter int MAX_CREDIT = CREDIT_MAX_DEF,
    parameter int CREDIT_W   = CREDIT_W_DEF
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [VC_NUM-1:0]          CREDIT_IN,
    input  logic [VC_NUM-1:0]          FLIT_SENT,
    output logic [VC_NUM*CREDIT_W-1:0] CREDIT_CNT,
    output logic [VC_NUM-1:0]          CREDIT_AVAIL,
    output logic [VC_NUM-1:0]          FLAG_SET,
    output logic [VC_NUM-1:0]          FLAG_RST,
    output logic                       ERR_OVF,
    output logic                       ERR_UDF
);

    logic [VC_NUM-1:0] ovf_vec;
    logic [VC_NUM-1:0] udf_vec;

    for (genvar i = 0; i < VC_NUM; i++) begin : g_vc
        m_credit_ctr_vc #(
            .MAX_CREDIT(MAX_CREDIT),
            .CREDIT_W  (CREDIT_W)
        ) u_vc (
            .clk      (CLK),
            .rst      (RST),
            .inc      (CREDIT_IN[i]),
            .dec      (FLIT_SENT[i]),
            .cnt      (CREDIT_CNT[i*CREDIT_W +: CREDIT_W]),
            .avail    (CREDIT_AVAIL[i]),
            .set_pulse(FLAG_SET[i]),
            .clr_pulse(FLAG_RST[i]),
            .ovf      (ovf_vec[i]),
            .udf      (udf_vec[i])
        );
    end

    // Error flags accumulate from any VC and clear only on reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ERR_OVF <= 1'b0;
            ERR_UDF <= 1'b0;
        end else begin
            ERR_OVF <= ERR_OVF | (|ovf_vec);
            ERR_UDF <= ERR_UDF | (|udf_vec);
        end
    end

endmodule

// File: tb/tb_m_credit_ctr.sv
// Testbench for m_credit_ctr: directed vector table, hand sequences, and randomized model comparison.
module tb_m_credit_ctr;

    localparam int MAXC = 4;

`ifdef CREDIT_LOOKAHEAD_EN
    localparam bit LA = 1'b1;
`else
    localparam bit LA = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] CREDIT_IN;
    logic [1:0] FLIT_SENT;
    logic [5:0] CREDIT_CNT;
    logic [1:0] CREDIT_AVAIL;
    logic [1:0] FLAG_SET;
    logic [1:0] FLAG_RST;
    logic       ERR_OVF;
    logic       ERR_UDF;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    m_credit_ctr dut (
        .CLK         (CLK),
        .RST         (RST),
        .CREDIT_IN   (CREDIT_IN),
        .FLIT_SENT   (FLIT_SENT),
        .CREDIT_CNT  (CREDIT_CNT),
        .CREDIT_AVAIL(CREDIT_AVAIL),
        .FLAG_SET    (FLAG_SET),
        .FLAG_RST    (FLAG_RST),
        .ERR_OVF     (ERR_OVF),
        .ERR_UDF     (ERR_UDF)
    );

    typedef struct {
        logic       rst;
        logic [1:0] inc;
        logic [1:0] dec;
        int         c0;
        int         c1;
        logic [1:0] set;
        logic [1:0] clr;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    int         m_cnt[2];
    logic [1:0] m_set;
    logic [1:0] m_clr;
    logic       m_ovf;
    logic       m_udf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic [1:0] inc, input logic [1:0] dec);
        RST       = r;
        CREDIT_IN = inc;
        FLIT_SENT = dec;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [1:0] exp_avail(input int c0, input int c1);
        logic [1:0] a;
        a = {c1 != 0, c0 != 0};
        if (LA) a = a | (CREDIT_IN & ~FLIT_SENT);
        return a;
    endfunction

    task automatic check_all(input string tag, input int c0, input int c1, input logic [1:0] set,
                             input logic [1:0] clr, input logic ovf, input logic udf);
        chk({tag, ".cnt0"}, 32'(CREDIT_CNT[2:0]), 32'(c0));
        chk({tag, ".cnt1"}, 32'(CREDIT_CNT[5:3]), 32'(c1));
        chk({tag, ".avail"}, 32'(CREDIT_AVAIL), 32'(exp_avail(c0, c1)));
        chk({tag, ".flag_set"}, 32'(FLAG_SET), 32'(set));
        chk({tag, ".flag_rst"}, 32'(FLAG_RST), 32'(clr));
        chk({tag, ".err_ovf"}, 32'(ERR_OVF), 32'(ovf));
        chk({tag, ".err_udf"}, 32'(ERR_UDF), 32'(udf));
    endtask

    task automatic model_step(input logic r, input logic [1:0] inc, input logic [1:0] dec);
        int prev;
        if (r) begin
            m_cnt[0] = MAXC;
            m_cnt[1] = MAXC;
            m_set    = 2'b00;
            m_clr    = 2'b00;
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                prev = m_cnt[v];
                if (inc[v] && !dec[v]) begin
                    if (m_cnt[v] == MAXC) m_ovf = 1'b1;
                    else m_cnt[v] = m_cnt[v] + 1;
                end else if (dec[v] && !inc[v]) begin
                    if (m_cnt[v] == 0) m_udf = 1'b1;
                    else m_cnt[v] = m_cnt[v] - 1;
                end
                m_set[v] = (prev == 0) && (m_cnt[v] != 0);
                m_clr[v] = (prev != 0) && (m_cnt[v] == 0);
            end
        end
    endtask

    initial begin
        RST       = 1'b1;
        CREDIT_IN = 2'b00;
        FLIT_SENT = 2'b00;

        //           rst   inc    dec    c0 c1 set    clr    ovf   udf
        vecs.push_back('{1'b1, 2'b00, 2'b00, 4, 4, 2'b00, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 2'b00, 2'b00, 4, 4, 2'b00, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 2'b01, 3, 4, 2'b00, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 2'b01, 2, 4, 2'b00, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 2'b01, 1, 4, 2'b00, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 2'b01, 0, 4, 2'b00, 2'b01, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 2'b00, 0, 4, 2'b00, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 2'b01, 2'b01, 0, 4, 2'b00, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 2'b01, 2'b00, 1, 4, 2'b01, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 2'b00, 1, 4, 2'b00, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 2'b01, 0, 4, 2'b00, 2'b01, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 2'b01, 0, 4, 2'b00, 2'b00, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 2'b00, 2'b00, 0, 4, 2'b00, 2'b00, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 2'b10, 2'b00, 0, 4, 2'b00, 2'b00, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'b10, 2'b10, 0, 4, 2'b00, 2'b00, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'b01, 2'b00, 1, 4, 2'b01, 2'b00, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 2'b01, 2'b00, 2, 4, 2'b00, 2'b00, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 2'b00, 2'b01, 4, 4, 2'b00, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 2'b00, 4, 4, 2'b00, 2'b00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 2'b10, 4, 3, 2'b00, 2'b00, 1'b0, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].inc, vecs[i].dec);
            check_all($sformatf("vec%0d", i), vecs[i].c0, vecs[i].c1, vecs[i].set,
                      vecs[i].clr, vecs[i].ovf, vecs[i].udf);
        end

        // Drain VC0 to empty, then probe the same-cycle availability of a returned credit.
        apply(1'b1, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++) apply(1'b0, 2'b00, 2'b01);
        apply(1'b0, 2'b00, 2'b00);
        chk("drain.avail0", 32'(CREDIT_AVAIL[0]), 32'(0));
        CREDIT_IN = 2'b01;
        #1;
        chk("lookahead.avail0", 32'(CREDIT_AVAIL[0]), 32'(LA));
        FLIT_SENT = 2'b01;
        #1;
        chk("lookahead_net0.avail0", 32'(CREDIT_AVAIL[0]), 32'(0));
        FLIT_SENT = 2'b00;
        apply(1'b0, 2'b01, 2'b00);
        chk("credit_back.cnt0", 32'(CREDIT_CNT[2:0]), 32'(1));
        chk("credit_back.set0", 32'(FLAG_SET[0]), 32'(1));
        apply(1'b0, 2'b00, 2'b00);
        chk("credit_back.set0_drop", 32'(FLAG_SET[0]), 32'(0));

        // Underflow then a long idle stretch: the error must persist.
        apply(1'b0, 2'b00, 2'b01);
        apply(1'b0, 2'b00, 2'b01);
        for (int i = 0; i < 20; i++) apply(1'b0, 2'b00, 2'b00);
        chk("sticky.err_udf", 32'(ERR_UDF), 32'(1));
        chk("sticky.err_ovf", 32'(ERR_OVF), 32'(0));

        // Randomized traffic against the reference model.
        model_step(1'b1, 2'b00, 2'b00);
        apply(1'b1, 2'b00, 2'b00);
        for (int n = 0; n < 600; n++) begin
            logic       r;
            logic [1:0] inc;
            logic [1:0] dec;
            r   = ($urandom_range(0, 59) == 0);
            inc = 2'($urandom);
            dec = 2'($urandom);
            model_step(r, inc, dec);
            apply(r, inc, dec);
            check_all($sformatf("rand%0d", n), m_cnt[0], m_cnt[1], m_set, m_clr, m_ovf, m_udf);
            chk($sformatf("rand%0d.exclusive", n), 32'(FLAG_SET & FLAG_RST), 32'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
